// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - VGA timing generator with pixel-clock divider and upscaled framebuffer scan-out
module vga_fb_scanout #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 31,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int COLOR_W  = 2,
    parameter int IMG_W    = 128,
    parameter int IMG_H    = 128,
    parameter int SCALE_SH = 1,
    parameter int RD_LAT   = 1,
    localparam int AW      = $clog2(IMG_W * IMG_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] bg_color,
    output logic                 fb_rd_en,
    output logic [AW-1:0]        fb_addr,
    input  logic [3*COLOR_W-1:0] fb_data,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic [COLOR_W-1:0]   r,
    output logic [COLOR_W-1:0]   g,
    output logic [COLOR_W-1:0]   b,
    output logic                 frame_start,
    output logic                 line_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);
    localparam int PW    = $clog2(CLK_DIV);
    localparam int CW3   = 3 * COLOR_W;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS0  = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS1  = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] X_IMG  = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS0  = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS1  = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] Y_IMG  = YW'(IMG_H);
    // An image taller than the y counter range can never clip vertically.
    localparam bit            Y_IMG_ALL = (IMG_H >= (1 << YW));
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_CAP    = PW'(RD_LAT);
    localparam logic          HS_LVL    = (HS_POL != 0);
    localparam logic          VS_LVL    = (VS_POL != 0);

    if (CLK_DIV < 2 || RD_LAT < 1 || RD_LAT >= CLK_DIV || (IMG_W << SCALE_SH) > H_ACTIVE) begin : g_param_check
        $error("vga_fb_scanout: illegal CLK_DIV / RD_LAT / image width combination");
    end

    function automatic logic [XW-1:0] next_x(input logic [XW-1:0] xi);
        return (xi == X_LAST) ? '0 : xi + 1'b1;
    endfunction

    function automatic logic [YW-1:0] next_y(input logic [XW-1:0] xi, input logic [YW-1:0] yi);
        if (xi != X_LAST) return yi;
        return (yi == Y_LAST) ? '0 : yi + 1'b1;
    endfunction

    function automatic logic in_img(input logic [XW-1:0] xi, input logic [YW-1:0] yi);
        logic [XW-1:0] ui;
        logic [YW-1:0] vi;
        ui = xi >> SCALE_SH;
        vi = yi >> SCALE_SH;
        return (xi < X_ACT) && (yi < Y_ACT) && (ui < X_IMG) && (Y_IMG_ALL || (vi < Y_IMG));
    endfunction

    logic [PW-1:0]  phase;
    logic [XW-1:0]  x, x_nx, tx, u_t;
    logic [YW-1:0]  y, y_nx, ty, v_t;
    logic           tick, win_t, rd_pend, hs_on, vs_on, de_nx;
    logic [AW-1:0]  addr_t;
    logic [CW3-1:0] stage, stage_nx, rgb, rgb_nx;

    assign tick = (phase == PH_LAST);

    // (x_nx, y_nx) is the pixel loaded at this tick; (tx, ty) is fetched during the period it is shown.
    always_comb begin
        x_nx     = next_x(x);
        y_nx     = next_y(x, y);
        tx       = next_x(x_nx);
        ty       = next_y(x_nx, y_nx);
        u_t      = tx >> SCALE_SH;
        v_t      = ty >> SCALE_SH;
        win_t    = in_img(tx, ty);
        addr_t   = AW'(32'(v_t) * 32'(IMG_W) + 32'(u_t));
        stage_nx = (phase == PH_CAP && rd_pend) ? fb_data : stage;
        hs_on    = (x_nx >= X_HS0) && (x_nx < X_HS1);
        vs_on    = (y_nx >= Y_VS0) && (y_nx < Y_VS1);
        de_nx    = (x_nx < X_ACT) && (y_nx < Y_ACT);
        rgb_nx   = in_img(x_nx, y_nx) ? stage_nx : (de_nx ? bg_color : '0);
    end

    // When RD_LAT == CLK_DIV-1 the capture edge is also the tick edge, hence stage_nx feeds rgb.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase       <= '0;
            x           <= X_LAST;
            y           <= Y_LAST;
            fb_rd_en    <= 1'b0;
            fb_addr     <= '0;
            rd_pend     <= 1'b0;
            stage       <= '0;
            hsync       <= ~HS_LVL;
            vsync       <= ~VS_LVL;
            de          <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            phase       <= tick ? '0 : phase + 1'b1;
            stage       <= stage_nx;
            fb_rd_en    <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            if (tick) begin
                x           <= x_nx;
                y           <= y_nx;
                fb_rd_en    <= win_t;
                rd_pend     <= win_t;
                if (win_t) fb_addr <= addr_t;
                hsync       <= hs_on ? HS_LVL : ~HS_LVL;
                vsync       <= vs_on ? VS_LVL : ~VS_LVL;
                de          <= de_nx;
                rgb         <= rgb_nx;
                frame_start <= (x_nx == '0) && (y_nx == '0);
                line_start  <= (x_nx == '0);
            end
        end
    end

    assign r = rgb[CW3-1 -: COLOR_W];
    assign g = rgb[2*COLOR_W-1 -: COLOR_W];
    assign b = rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb/tb_vga_fb_scanout.sv - directed bench: default-width 800-pixel timing plus a tiny inverted-polarity config
module tb_vga_fb_scanout;

    logic clk, rst;
    int   k;
    int   pass_cnt, tot_cnt;

    // Big instance: default horizontal timing, shortened vertical timing (V_TOT = 15).
    logic        b_rd, b_hs, b_vs, b_de, b_fs, b_ls;
    logic [13:0] b_addr;
    logic [5:0]  b_fbd;
    logic [1:0]  b_r, b_g, b_b;
    // Small instance: 12x9 total, 8x6 active, 4x4 image, CLK_DIV=3, RD_LAT=2, inverted syncs.
    logic        s_rd, s_hs, s_vs, s_de, s_fs, s_ls;
    logic [3:0]  s_addr;
    logic [5:0]  s_d1, s_d2;
    logic [1:0]  s_r, s_g, s_b;

    localparam logic [5:0] BG_B = 6'h2D;
    localparam logic [5:0] BG_S = 6'h1B;

    vga_fb_scanout #(.V_ACTIVE(11), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
        .clk(clk), .rst(rst), .bg_color(BG_B), .fb_rd_en(b_rd), .fb_addr(b_addr), .fb_data(b_fbd),
        .hsync(b_hs), .vsync(b_vs), .de(b_de), .r(b_r), .g(b_g), .b(b_b),
        .frame_start(b_fs), .line_start(b_ls)
    );

    vga_fb_scanout #(.CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(0), .VS_POL(0),
                     .IMG_W(4), .IMG_H(4), .SCALE_SH(0), .RD_LAT(2)) dut_s (
        .clk(clk), .rst(rst), .bg_color(BG_S), .fb_rd_en(s_rd), .fb_addr(s_addr), .fb_data(s_d2),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .r(s_r), .g(s_g), .b(s_b),
        .frame_start(s_fs), .line_start(s_ls)
    );

    function automatic logic [5:0] sdata(input int i);
        return 6'((i * 5) & 63);
    endfunction

    function automatic int pk(input int px, input int py);
        return 5 + 4 * (py * 800 + px);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Framebuffer models: data = addr[5:0] with 1-clk latency; sdata() with 2-clk latency.
    always @(posedge clk) begin
        b_fbd <= b_rd ? b_addr[5:0] : ~b_fbd;
        s_d1  <= s_rd ? sdata(int'(s_addr)) : ~s_d1;
        s_d2  <= s_d1;
    end

    int de_cnt, hs_cnt, s_rd_cnt, s_chk, s_err;

    always @(negedge clk) begin
        if (!rst) begin
            if (k >= 4 && k < 48004 && b_de) de_cnt++;
            if (k >= 4 && k < 3204 && b_hs)  hs_cnt++;
            if (k >= 1000 && k < 1324 && s_rd) s_rd_cnt++;
        end
    end

    // Small instance is checked every cycle against a pixel position derived from time since reset.
    always @(negedge clk) begin
        if (!rst) begin
            int p, ph, sx, sy;
            logic [5:0] e_rgb;
            logic e_de, e_hs, e_vs, e_fs, e_ls;
            if (k < 3) begin
                e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0; e_fs = 1'b0; e_ls = 1'b0;
            end else begin
                p  = (k - 3) / 3;
                ph = (k - 3) % 3;
                sx = p % 12;
                sy = (p / 12) % 9;
                e_de  = (sx < 8) && (sy < 6);
                e_hs  = !((sx >= 9) && (sx < 11));
                e_vs  = (sy != 7);
                e_rgb = (sx < 4 && sy < 4) ? sdata(sy * 4 + sx) : (e_de ? BG_S : 6'h00);
                e_fs  = (ph == 0) && (sx == 0) && (sy == 0);
                e_ls  = (ph == 0) && (sx == 0);
            end
            s_chk++;
            if ({s_hs, s_vs, s_de, s_r, s_g, s_b, s_fs, s_ls} !== {e_hs, e_vs, e_de, e_rgb, e_fs, e_ls})
                s_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_k(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (k != n && guard < 100000);
        chk("wait_k", k, n);
    endtask

    initial begin
        pass_cnt = 0; tot_cnt = 0;
        de_cnt = 0; hs_cnt = 0; s_rd_cnt = 0; s_chk = 0; s_err = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", b_hs, 0);
        chk("rst_vsync", b_vs, 0);
        chk("rst_de", b_de, 0);
        chk("rst_rgb", {b_r, b_g, b_b}, 0);
        chk("rst_pulses", {b_fs, b_ls}, 0);
        chk("rst_rd_en", b_rd, 0);
        chk("rst_s_syncs", {s_hs, s_vs}, 2'b11);
        @(posedge clk); #1 rst = 1'b0;

        wait_k(3);  chk("fs_k3", b_fs, 0);
        wait_k(4);  chk("fs_k4", b_fs, 1); chk("ls_k4", b_ls, 1); chk("de_00", b_de, 1);
        wait_k(5);  chk("fs_k5", b_fs, 0);
        wait_k(pk(256, 0));  chk("rgb_256_0_bg", {b_r, b_g, b_b}, BG_B);
        wait_k(pk(655, 0));  chk("hs_655", b_hs, 0);
        wait_k(pk(656, 0));  chk("hs_656", b_hs, 1);
        wait_k(pk(751, 0));  chk("hs_751", b_hs, 1);
        wait_k(pk(752, 0));  chk("hs_752", b_hs, 0);
        wait_k(3203); chk("ls_k3203", b_ls, 0);
        wait_k(3204); chk("ls_k3204", b_ls, 1);
        wait_k(pk(5, 3));    chk("rgb_5_3", {b_r, b_g, b_b}, 6'd2);
        wait_k(pk(7, 5));    chk("rgb_7_5", {b_r, b_g, b_b}, 6'd3);
        wait_k(pk(255, 10)); chk("rgb_255_10", {b_r, b_g, b_b}, 6'd63);
        wait_k(pk(639, 10)); chk("rgb_639_10_bg", {b_r, b_g, b_b}, BG_B); chk("de_639_10", b_de, 1);
        wait_k(pk(700, 10)); chk("rgb_700_10", {b_r, b_g, b_b}, 0); chk("de_700_10", b_de, 0);
        wait_k(pk(0, 11));   chk("de_0_11", b_de, 0); chk("rgb_0_11", {b_r, b_g, b_b}, 0);
        wait_k(pk(799, 11)); chk("vs_799_11", b_vs, 0);
        wait_k(pk(0, 12));   chk("vs_0_12", b_vs, 1);
        wait_k(pk(799, 13)); chk("vs_799_13", b_vs, 1);
        wait_k(pk(0, 14));   chk("vs_0_14", b_vs, 0);
        wait_k(48003); chk("fs_k48003", b_fs, 0);
        wait_k(48004); chk("fs_k48004", b_fs, 1);
        chk("de_clks_per_frame", de_cnt, 640 * 11 * 4);
        chk("hs_clks_per_line", hs_cnt, 384);
        chk("s_rd_per_frame", s_rd_cnt, 16);

        wait_k(pk(300, 5) + 12000 * 4);
        chk("de_300_5", b_de, 1);
        chk("rgb_300_5_bg", {b_r, b_g, b_b}, BG_B);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_hsync", b_hs, 0);
        chk("mid_rst_de", b_de, 0);
        chk("mid_rst_rgb", {b_r, b_g, b_b}, 0);
        chk("mid_rst_rd_en", b_rd, 0);
        chk("mid_rst_s_syncs", {s_hs, s_vs}, 2'b11);
        wait_k(3);  chk("re_fs_k3", b_fs, 0);
        wait_k(4);  chk("re_fs_k4", b_fs, 1);
        wait_k(13); chk("re_rgb_2_0", {b_r, b_g, b_b}, 6'd1);

        chk("s_pixel_errors", s_err, 0);
        chk("s_pixels_checked", (s_chk > 1000), 1);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
